button_debounce: RTL and testbench

//   Cleans the four raw arcade-button inputs before they reach the button latch/poll stage.
//   - Synchronizes each pin to the clock domain and debounces it.
//   - Suppresses chords so the downstream stage only ever sees one-hot or all-zero levels.
//   - Emits single-cycle press and release pulses for the game FSM and sound logic.

---
 rtl/button_debounce_pkg.sv | 23 ++
 rtl/button_debounce_channel.sv | 83 ++++++++
 rtl/button_debounce.sv | 61 ++++++
 tb/tb_button_debounce.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_debounce_pkg.sv
// Shared definitions for the arcade-button front end: color codes reused by the latch stage,
// debounce channel state encoding and the chord-detect helper.
package button_debounce_pkg;

  localparam int unsigned NUM_COLORS   = 4;
  localparam int unsigned COLOR_RED    = 0;
  localparam int unsigned COLOR_BLUE   = 1;
  localparam int unsigned COLOR_GREEN  = 2;
  localparam int unsigned COLOR_YELLOW = 3;

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } db_state_e;

  // True when two or more bits are set: clearing the lowest set bit leaves something behind.
  function automatic logic multi_hot(input logic [NUM_COLORS-1:0] v);
    return (v & (v - NUM_COLORS'(1))) != '0;
  endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: two-flop synchronizer, debounce FSM with saturating stable-sample counter,
// registered clean level and single-cycle press/release pulses.
module button_debounce_channel
  import button_debounce_pkg::*;
#(
  parameter int unsigned DebounceCycles = 1_000_000,
  parameter bit          ActiveLow      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic clean_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned     CntW   = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles);

  logic [1:0]      sync_q;
  logic            sync;
  db_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_inc;
  logic            clean_q;
  logic            press_q;
  logic            release_q;

  assign sync = sync_q[1];

  // Stable samples seen including the current one; reaching CntMax accepts the new level.
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= '0;
      state_q   <= StIdle;
      cnt_q     <= '0;
      clean_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], raw_i ^ ActiveLow};
      press_q   <= 1'b0;
      release_q <= 1'b0;
      unique case (state_q)
        StIdle, StPressWait: begin
          if (!sync) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_inc == CntMax) begin
            state_q <= StPressed;
            cnt_q   <= '0;
            clean_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            state_q <= StPressWait;
            cnt_q   <= cnt_inc;
          end
        end
        StPressed, StReleaseWait: begin
          if (sync) begin
            state_q <= StPressed;
            cnt_q   <= '0;
          end else if (cnt_inc == CntMax) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            clean_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            state_q <= StReleaseWait;
            cnt_q   <= cnt_inc;
          end
        end
      endcase
    end
  end

  assign clean_o   = clean_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_debounce.sv
// Four-button front end: per-color debounce channels plus chord masking so the latch stage only
// ever sees one-hot or all-zero levels.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       red_raw,
  input  logic       blue_raw,
  input  logic       green_raw,
  input  logic       yellow_raw,
  output logic       red_button,
  output logic       blue_button,
  output logic       green_button,
  output logic       yellow_button,
  output logic [3:0] press_pulse,
  output logic [3:0] release_pulse,
  output logic       multi_press
);

  logic [NUM_COLORS-1:0] raw;
  logic [NUM_COLORS-1:0] clean;
  logic [NUM_COLORS-1:0] level;

  always_comb begin
    raw               = '0;
    raw[COLOR_RED]    = red_raw;
    raw[COLOR_BLUE]   = blue_raw;
    raw[COLOR_GREEN]  = green_raw;
    raw[COLOR_YELLOW] = yellow_raw;
  end

  for (genvar i = 0; i < NUM_COLORS; i++) begin : g_chan
    button_debounce_channel #(
      .DebounceCycles(DEBOUNCE_CYCLES),
      .ActiveLow     (ACTIVE_LOW)
    ) u_chan (
      .clk_i    (clock),
      .rst_i    (reset),
      .raw_i    (raw[i]),
      .clean_o  (clean[i]),
      .press_o  (press_pulse[i]),
      .release_o(release_pulse[i])
    );
  end

  // Pulses pass through unmasked; only the levels are blanked during a chord.
  always_comb begin
    multi_press = multi_hot(clean);
    level       = multi_press ? '0 : clean;
  end

  assign red_button    = level[COLOR_RED];
  assign blue_button   = level[COLOR_BLUE];
  assign green_button  = level[COLOR_GREEN];
  assign yellow_button = level[COLOR_YELLOW];

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios plus randomized raw traffic, all checked against a
// run-length debounce model; a second instance covers active-low pins.
module tb_button_debounce;
  import button_debounce_pkg::*;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] raw = 4'b0000;
  logic [3:0] raw_al = 4'b1111;

  logic [3:0] lvl, prs, rel;
  logic       mp;
  logic [3:0] lvl_al, prs_al, rel_al;
  logic       mp_al;

  int total = 0;
  int bad = 0;

  // Reference model: 2-deep sync pipeline and a count of consecutive samples disagreeing with clean.
  logic [3:0]  m_s1, m_s2, m_clean, m_press, m_rel;
  int unsigned m_run[4];

  button_debounce #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0)) dut (
    .clock(clk), .reset(rst),
    .red_raw(raw[COLOR_RED]), .blue_raw(raw[COLOR_BLUE]),
    .green_raw(raw[COLOR_GREEN]), .yellow_raw(raw[COLOR_YELLOW]),
    .red_button(lvl[COLOR_RED]), .blue_button(lvl[COLOR_BLUE]),
    .green_button(lvl[COLOR_GREEN]), .yellow_button(lvl[COLOR_YELLOW]),
    .press_pulse(prs), .release_pulse(rel), .multi_press(mp)
  );

  button_debounce #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) dut_al (
    .clock(clk), .reset(rst),
    .red_raw(raw_al[COLOR_RED]), .blue_raw(raw_al[COLOR_BLUE]),
    .green_raw(raw_al[COLOR_GREEN]), .yellow_raw(raw_al[COLOR_YELLOW]),
    .red_button(lvl_al[COLOR_RED]), .blue_button(lvl_al[COLOR_BLUE]),
    .green_button(lvl_al[COLOR_GREEN]), .yellow_button(lvl_al[COLOR_YELLOW]),
    .press_pulse(prs_al), .release_pulse(rel_al), .multi_press(mp_al)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_step();
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_clean = '0; m_press = '0; m_rel = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
    end else begin
      m_press = '0;
      m_rel   = '0;
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_clean[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_clean[i] = ~m_clean[i];
            if (m_clean[i]) m_press[i] = 1'b1;
            else m_rel[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  endtask

  function automatic logic [12:0] model_vec();
    logic multi;
    multi = $countones(m_clean) >= 2;
    return {multi ? 4'b0000 : m_clean, m_press, m_rel, multi};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {lvl, prs, rel, mp};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; raw = '0; raw_al = 4'b1111;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int rise = -1;
    int npress = 0;
    rst = 1'b1; raw = 4'b0001; raw_al = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({dut_vec(), lvl_al, prs_al, rel_al, mp_al} !== 26'd0) begin
        bad++;
        $display("FAIL reset_outputs t=%0t got=%h want=0", $time, {dut_vec(), lvl_al, prs_al,
                 rel_al, mp_al});
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL reset_model t=%0t got=%h want=%h", $time, dut_vec(), model_vec());
      end
      if (lvl[0] && rise < 0) rise = k;
      if (prs != 4'b0000) begin
        npress++;
        total++;
        if (prs !== 4'b0001) begin
          bad++;
          $display("FAIL reset_press_value got=%b want=0001", prs);
        end
      end
    end
    total++;
    if (rise != 5) begin
      bad++;
      $display("FAIL reset_latency got=%0d want=5", rise);
    end
    total++;
    if (npress != 1) begin
      bad++;
      $display("FAIL reset_press_count got=%0d want=1", npress);
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat = 5'b01101;  // applied LSB first: 1,0,1,1,0
    int rise = -1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      raw[COLOR_BLUE] = pat[k];
      tick();
      total++;
      if (prs !== 4'b0000 || lvl !== 4'b0000) begin
        bad++;
        $display("FAIL bounce_toggle t=%0t got=%b/%b want=0000/0000", $time, prs, lvl);
      end
    end
    raw[COLOR_BLUE] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL bounce_model t=%0t got=%h want=%h", $time, dut_vec(), model_vec());
      end
      if (lvl[COLOR_BLUE] && rise < 0) rise = k;
    end
    total++;
    if (rise != 5 || lvl !== 4'b0010) begin
      bad++;
      $display("FAIL bounce_rise got=%0d/%b want=5/0010", rise, lvl);
    end
  endtask

  task automatic test_release();
    int nrel = 0;
    do_reset();
    raw[COLOR_GREEN] = 1'b1;
    repeat (8) tick();
    total++;
    if (lvl !== 4'b0100) begin
      bad++;
      $display("FAIL release_setup got=%b want=0100", lvl);
    end
    for (int k = 0; k < 9; k++) begin
      raw[COLOR_GREEN] = (k >= 3);
      tick();
      total++;
      if (rel !== 4'b0000 || lvl !== 4'b0100 || dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL release_glitch t=%0t got=%b/%b want=0000/0100", $time, rel, lvl);
      end
    end
    raw[COLOR_GREEN] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (rel != 4'b0000) begin
        nrel++;
        total++;
        if (rel !== 4'b0100) begin
          bad++;
          $display("FAIL release_value got=%b want=0100", rel);
        end
      end
    end
    total++;
    if (nrel != 1 || lvl !== 4'b0000) begin
      bad++;
      $display("FAIL release_once got=%0d/%b want=1/0000", nrel, lvl);
    end
  endtask

  task automatic test_chord();
    int seen = 0;
    do_reset();
    raw[COLOR_RED] = 1'b1;
    repeat (8) tick();
    raw[COLOR_YELLOW] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL chord_model t=%0t got=%h want=%h", $time, dut_vec(), model_vec());
      end
      if (prs != 4'b0000) begin
        seen++;
        total++;
        if (prs !== 4'b1000 || lvl !== 4'b0000 || mp !== 1'b1) begin
          bad++;
          $display("FAIL chord_press got=%b/%b/%b want=1000/0000/1", prs, lvl, mp);
        end
      end
    end
    total++;
    if (seen != 1) begin
      bad++;
      $display("FAIL chord_press_count got=%0d want=1", seen);
    end
    raw[COLOR_YELLOW] = 1'b0;
    repeat (10) tick();
    total++;
    if (lvl !== 4'b0001 || mp !== 1'b0) begin
      bad++;
      $display("FAIL chord_restore got=%b/%b want=0001/0", lvl, mp);
    end
  endtask

  task automatic test_simultaneous();
    int seen = 0;
    do_reset();
    raw = 4'b0110;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (prs != 4'b0000) begin
        seen++;
        total++;
        if (prs !== 4'b0110 || mp !== 1'b1 || lvl !== 4'b0000) begin
          bad++;
          $display("FAIL simul_press got=%b/%b/%b want=0110/1/0000", prs, mp, lvl);
        end
      end
    end
    total++;
    if (seen != 1) begin
      bad++;
      $display("FAIL simul_press_count got=%0d want=1", seen);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    do_reset();
    for (int k = 0; k < 500; k++) begin
      if (hold == 0) begin
        raw  = 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 7);
      end
      hold--;
      rst = ($urandom_range(0, 99) == 0);
      tick();
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++;
        $display("FAIL random_model t=%0t got=%h want=%h", $time, dut_vec(), model_vec());
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_active_low();
    int rise = -1;
    do_reset();
    raw_al[COLOR_RED] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (lvl_al[COLOR_RED] && rise < 0) rise = k;
      total++;
      if (prs_al !== ((k == 5) ? 4'b0001 : 4'b0000)) begin
        bad++;
        $display("FAIL active_low_pulse k=%0d got=%b", k, prs_al);
      end
    end
    total++;
    if (rise != 5 || lvl_al !== 4'b0001 || mp_al !== 1'b0) begin
      bad++;
      $display("FAIL active_low_rise got=%0d/%b want=5/0001", rise, lvl_al);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_release();
    test_chord();
    test_simultaneous();
    test_random();
    test_active_low();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
